// File: rtl/i_cache_pkg.sv
// Shared defaults, address-field helpers and FSM state type for the
// direct-mapped instruction cache.
package i_cache_pkg;

  localparam int BIT_SIZE_D = 32;
  localparam int MEM_SIZE_D = 16;
  localparam int LINES_D    = 16;
  localparam int WORDS_D    = 4;

  // Byte address layout: {tag, index, word offset, 2'b00}
  localparam int OFF_LSB = 2;

  function automatic int idx_lsb(input int words);
    return OFF_LSB + $clog2(words);
  endfunction

  function automatic int tag_lsb(input int lines, input int words);
    return idx_lsb(words) + $clog2(lines);
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, LAST} state_t;

endpackage

// File: rtl/i_cache_array.sv
// Cache storage: per-line valid bits and tags plus the word array, with one
// write port and one combinational read port.
module i_cache_array #(
  parameter int bit_size = 32,
  parameter int LINES    = 16,
  parameter int WORDS    = 4,
  parameter int TAG_W    = 8
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [$clog2(LINES)-1:0]   rd_idx,
  input  logic [$clog2(WORDS)-1:0]   rd_off,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [bit_size-1:0]        rd_data,
  input  logic                       wr_en,
  input  logic [$clog2(LINES)-1:0]   wr_idx,
  input  logic [$clog2(WORDS)-1:0]   wr_off,
  input  logic [bit_size-1:0]        wr_data,
  input  logic                       tag_we,
  input  logic [TAG_W-1:0]           wr_tag
);

  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tags [LINES];
  logic [bit_size-1:0] data [LINES*WORDS];

  // Invalidate beats a concurrent line-valid set
  always_ff @(posedge clk) begin
    if (rst || clr)
      valid <= '0;
    else if (tag_we)
      valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      data[{wr_idx, wr_off}] <= wr_data;
    if (tag_we)
      tags[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[{rd_idx, rd_off}];

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache: combinational hit lookup, word-by-word
// line refill from instruction memory, whole-cache flush.
module i_cache_dm
  import i_cache_pkg::*;
#(
  parameter int bit_size = BIT_SIZE_D,
  parameter int mem_size = MEM_SIZE_D,
  parameter int LINES    = LINES_D,
  parameter int WORDS    = WORDS_D
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [mem_size-1:0] cpu_addr,
  input  logic                flush,
  output logic                IC_stall_out,
  output logic [bit_size-1:0] I_cache_instr_out,
  output logic [mem_size-1:0] IM_Address,
  output logic                IM_en_Read,
  input  logic [bit_size-1:0] Instruction
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int IDX_LSB = idx_lsb(WORDS);
  localparam int TAG_LSB = tag_lsb(LINES, WORDS);
  localparam int TAG_W   = mem_size - TAG_LSB;
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);

  state_t state, next_state, view;

  logic [OFF_W-1:0] cnt;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;

  logic [OFF_W-1:0]    cur_off;
  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [bit_size-1:0] rd_data;
  logic                hit, start_fill, wr_en, tag_we;
  logic                unused_addr_bits;

  assign cur_off          = cpu_addr[OFF_LSB +: OFF_W];
  assign cur_idx          = cpu_addr[IDX_LSB +: IDX_W];
  assign cur_tag          = cpu_addr[TAG_LSB +: TAG_W];
  assign unused_addr_bits = ^cpu_addr[OFF_LSB-1:0];
  assign hit              = rd_valid && (rd_tag == cur_tag);

  i_cache_array #(
    .bit_size (bit_size),
    .LINES    (LINES),
    .WORDS    (WORDS),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .rd_idx   (cur_idx),
    .rd_off   (cur_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (lat_idx),
    .wr_off   (cnt - OFF_W'(1)),
    .wr_data  (Instruction),
    .tag_we   (tag_we),
    .wr_tag   (lat_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_tag <= '0;
      lat_idx <= '0;
    end else begin
      state <= next_state;
      if (start_fill) begin
        cnt     <= '0;
        lat_tag <= cur_tag;
        lat_idx <= cur_idx;
      end else if (state == FILL) begin
        cnt <= cnt + OFF_W'(1);
      end
    end
  end

  // Reset masks the refill outputs in the same cycle; word k-1 is written
  // while word k is requested, so LAST (cnt wrapped to 0) writes the final word.
  always_comb begin
    view              = rst ? IDLE : state;
    next_state        = state;
    start_fill        = 1'b0;
    IC_stall_out      = 1'b0;
    I_cache_instr_out = '0;
    IM_en_Read        = 1'b0;
    IM_Address        = '0;
    wr_en             = 1'b0;
    tag_we            = 1'b0;
    case (view)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            I_cache_instr_out = rd_data;
          end else begin
            IC_stall_out = 1'b1;
            start_fill   = 1'b1;
            next_state   = FILL;
          end
        end
      end
      FILL: begin
        IC_stall_out = 1'b1;
        IM_en_Read   = 1'b1;
        IM_Address   = {lat_tag, lat_idx, cnt, {OFF_LSB{1'b0}}};
        wr_en        = (cnt != '0);
        if (cnt == CNT_LAST)
          next_state = LAST;
      end
      LAST: begin
        IC_stall_out = 1'b1;
        wr_en        = 1'b1;
        tag_we       = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush)
      next_state = IDLE;
  end

endmodule

// File: tb/tb_i_cache_dm.sv
// Bench for i_cache_dm: line-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_i_cache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        flush = 1'b0;
  logic        IC_stall_out;
  logic [31:0] I_cache_instr_out;
  logic [15:0] IM_Address;
  logic        IM_en_Read;
  logic [31:0] Instruction = '0;

  i_cache_dm #(
    .bit_size (32),
    .mem_size (16),
    .LINES    (16),
    .WORDS    (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_req           (cpu_req),
    .cpu_addr          (cpu_addr),
    .flush             (flush),
    .IC_stall_out      (IC_stall_out),
    .I_cache_instr_out (I_cache_instr_out),
    .IM_Address        (IM_Address),
    .IM_en_Read        (IM_en_Read),
    .Instruction       (Instruction)
  );

  always #5 clk = ~clk;

  // Instruction memory: read data one cycle after the strobe
  logic [31:0] im [16384];
  always @(posedge clk)
    if (IM_en_Read) Instruction <= im[IM_Address[15:2]];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: which lines hold which tag, and how far a refill has got
  logic [15:0] mvalid = '0;
  logic [7:0]  mtag [16];
  int          busy = 0;
  logic [7:0]  ftag = '0;
  logic [3:0]  fidx = '0;

  function automatic logic mhit(input logic [15:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[15:8]);
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      mvalid <= '0;
      busy   <= 0;
    end else if (busy == 0) begin
      if (cpu_req && !mhit(cpu_addr)) begin
        busy <= 1;
        ftag <= cpu_addr[15:8];
        fidx <= cpu_addr[7:4];
      end
    end else if (busy < 5) begin
      busy <= busy + 1;
    end else begin
      mvalid[fidx] <= 1'b1;
      mtag[fidx]   <= ftag;
      busy         <= 0;
    end
  end

  always @(negedge clk) begin
    logic        e_stall, e_en;
    logic [31:0] e_instr;
    logic [15:0] e_addr;
    if (chk_en) begin
      e_stall = 1'b0; e_en = 1'b0; e_instr = '0; e_addr = '0;
      if (rst || busy == 0) begin
        if (cpu_req) begin
          if (mhit(cpu_addr)) e_instr = im[cpu_addr[15:2]];
          else                e_stall = 1'b1;
        end
      end else begin
        e_stall = 1'b1;
        if (busy <= 4) begin
          e_en   = 1'b1;
          e_addr = {ftag, fidx, 2'(busy - 1), 2'b00};
        end
      end
      chk("stall", 32'(IC_stall_out), 32'(e_stall));
      chk("instr", I_cache_instr_out, e_instr);
      chk("im_en", 32'(IM_en_Read), 32'(e_en));
      chk("im_addr", 32'(IM_Address), 32'(e_addr));
    end
  end

  logic [15:0] imq [$];

  task automatic fetch(input logic [15:0] a, output int stalls, output logic [31:0] data);
    cpu_req = 1'b1;
    cpu_addr = a;
    stalls = 0;
    imq.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!IC_stall_out) break;
      stalls++;
      if (IM_en_Read) imq.push_back(IM_Address);
      @(posedge clk); #1;
    end
    data = I_cache_instr_out;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fetch_chk(input string nm, input logic [15:0] a, input int exp_stalls);
    int s;
    logic [31:0] d;
    fetch(a, s, d);
    chk({nm, "_stalls"}, 32'(s), 32'(exp_stalls));
    chk({nm, "_data"}, d, im[a[15:2]]);
  endtask

  initial begin
    int s, hits, misses;
    logic [31:0] d;
    logic [15:0] a;
    for (int i = 0; i < 16384; i++) im[i] = $urandom;

    // Reset and idle outputs
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(IC_stall_out), 32'd0);
    chk("rst_en", 32'(IM_en_Read), 32'd0);
    chk("rst_addr", 32'(IM_Address), 32'd0);
    chk("rst_instr", I_cache_instr_out, 32'd0);
    @(posedge clk); #1;

    // Cold fetch of 0x0000
    fetch(16'h0000, s, d);
    chk("cold_stalls", 32'(s), 32'd6);
    chk("cold_nreq", 32'(imq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("cold_im_addr", (i < imq.size()) ? 32'(imq[i]) : 32'hFFFF_FFFF, 32'(4 * i));
    chk("cold_data", d, im[0]);

    // Rest of the line hits with no memory traffic
    for (int i = 1; i < 4; i++) begin
      fetch(16'(4 * i), s, d);
      chk("seq_stalls", 32'(s), 32'd0);
      chk("seq_nreq", 32'(imq.size()), 32'd0);
      chk("seq_data", d, im[i]);
    end

    // Same index, different tags: each refill replaces the other
    fetch_chk("conflict_a", 16'h0100, 6);
    fetch_chk("conflict_b", 16'h0000, 6);
    fetch_chk("conflict_c", 16'h0004, 0);
    idle(1);

    // Reset in the middle of a refill leaves no partial line
    cpu_req = 1'b1;
    cpu_addr = 16'h0200;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("midrst_en", 32'(IM_en_Read), 32'd0);
    chk("midrst_stall", 32'(IC_stall_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_en", 32'(IM_en_Read), 32'd0);
    chk("postrst_addr", 32'(IM_Address), 32'd0);
    @(posedge clk); #1;
    fetch_chk("after_rst", 16'h0200, 6);

    // Fill lines 0..3, flush, then everything misses again
    for (int i = 0; i < 4; i++) fetch(16'(16 * i), s, d);
    fetch_chk("pre_flush", 16'h0010, 0);
    idle(1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch_chk("post_flush", 16'h0010, 6);

    // Flush during a refill aborts it
    cpu_req = 1'b1;
    cpu_addr = 16'h0040;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("abort_stall", 32'(IC_stall_out), 32'd0);
    chk("abort_en", 32'(IM_en_Read), 32'd0);
    @(posedge clk); #1;
    fetch_chk("abort_refetch", 16'h0040, 6);

    // 12-instruction loop, 10 passes, from cold
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    hits = 0;
    misses = 0;
    for (int p = 0; p < 10; p++)
      for (int i = 0; i < 12; i++) begin
        fetch(16'(16'h1000 + 4 * i), s, d);
        if (s == 0) hits++;
        else misses++;
      end
    chk("loop_misses", 32'(misses), 32'd3);
    chk("loop_hits", 32'(hits), 32'd117);
    idle(1);

    // Randomized traffic over a small tag range so lines get reused
    for (int c = 0; c < 3000; c++) begin
      a = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
              ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      cpu_addr = a;
      cpu_req  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 79) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    flush = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i_cache_dm.md
I_CACHE_DM -- requirements
Module: i_cache_dm

Interface
REQ-001 SHALL have parameter bit_size, default 32, meaning instruction/data width.
REQ-002 SHALL have parameter mem_size, default 16, meaning byte-address width.
REQ-003 SHALL have parameter LINES, default 16, meaning number of direct-mapped lines.
REQ-004 SHALL have parameter WORDS, default 4, meaning words per line.
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cpu_req  in  1  fetch request valid.
REQ-008 SHALL have port cpu_addr  in  mem_size  fetch byte address; [1:0] ignored.
REQ-009 SHALL have port flush  in  1  invalidate all lines.
REQ-010 SHALL have port IC_stall_out  out  1  fetch not satisfied this cycle.
REQ-011 SHALL have port I_cache_instr_out  out  bit_size  fetched instruction.
REQ-012 SHALL have port IM_Address  out  mem_size  refill byte address to IM.
REQ-013 SHALL have port IM_en_Read  out  1  IM read strobe.
REQ-014 SHALL have port Instruction  in  bit_size  IM read data, valid one cycle after IM_en_Read.

Function
REQ-015 Address split SHALL be: word offset [3:2], index [7:4], tag [15:8] (defaults).
REQ-016 Hit SHALL be: state IDLE, cpu_req=1, line valid, stored tag == addr tag; same cycle, I_cache_instr_out = stored word, IC_stall_out=0 (combinational lookup).
REQ-017 When cpu_req=0 in IDLE: IC_stall_out=0, I_cache_instr_out=0.
REQ-018 Miss in IDLE (cycle M) SHALL assert IC_stall_out=1, I_cache_instr_out=0, latch tag/index, clear counter, go to FILL.
REQ-019 FILL (cycles M+1..M+4) SHALL drive IM_en_Read=1, IM_Address={tag,index,cnt,2'b00}, cnt 0..3, then go to LAST.
REQ-020 Word cnt-1 SHALL be written from Instruction in cycles M+2..M+4; LAST (M+5) SHALL write word 3, set tag and valid, go to IDLE.
REQ-021 IC_stall_out SHALL be 1 from M through M+5 (6 cycles); cycle M+6 re-looks-up and hits.
REQ-022 Outside FILL, IM_en_Read=0 and IM_Address=0.
REQ-023 cpu_addr changes during FILL/LAST SHALL be ignored; refill uses latched address; IDLE lookup uses current address.
REQ-024 A line SHALL never become valid with partial data.
REQ-025 flush SHALL clear all valid bits in 1 cycle; in FILL/LAST it aborts refill, next state IDLE; flush has priority over the line-valid write of LAST.
REQ-026 Refill of an index SHALL overwrite any previous tag (direct-mapped replacement, no write-back).

Reset
REQ-027 rst=1 at a clock edge SHALL clear all valid bits, counter, latched address, state to IDLE, regardless of state (including mid-fill).
REQ-028 During and immediately after reset: IC_stall_out=0 unless cpu_req misses, IM_en_Read=0, IM_Address=0, I_cache_instr_out=0.
REQ-029 Data and tag arrays SHALL NOT require reset.

Structure
REQ-030 Package i_cache_pkg SHALL hold default widths, field positions (offset/index/tag), and FSM state type {IDLE, FILL, LAST}.
REQ-031 Storage (valid, tag, data arrays, one write port, one combinational read port) SHALL be sub-module i_cache_array; FSM and hit logic in i_cache_dm.

Verification
REQ-032 Cold fetch 0x0000 after reset -> stall 6 cycles, IM_Address 0x0000,0x0004,0x0008,0x000C, then hit returning IM word 0.
REQ-033 Sequential fetch 0x0004,0x0008,0x000C after line fill -> 3 hits, stall 0, no IM_en_Read.
REQ-034 Fetch 0x0100 then 0x0000 (same index 0, tags 0x01/0x00) -> two 6-cycle misses, second refill overwrites, returns correct data.
REQ-035 rst pulsed at cycle M+3 of a fill -> state IDLE, IM_en_Read=0, next fetch of same address misses (no partial line).
REQ-036 flush after filling lines 0..3 -> fetch 0x0010 misses; flush during FILL -> line stays invalid.
REQ-037 Loop of 12 instructions repeated 10 times from cold -> 3 misses, hit rate >0.9, all outputs match IM contents.
